n64_vinfo_seq: RTL and testbench
================================

Name: n64_vinfo_seq

Overview:
- Video-info sequencer in front of the 240p de-blur estimator and blanking logic.
- Tracks the N64 4-phase data bus (sync, R, G, B) and generates `data_cnt` and `blurry_pixel_pos`.
- Classifies the video mode (PAL/NTSC, 480i/240p) per frame, keeps the registered previous-word vector, and packs the 7-bit parameter bus consumed by the de-blur stage.

Parameters:
- color_width_i, 7, width of one colour component on D_i.
- PAL_LINE_TH, 10'd288, a frame whose line count is >= this value is classed PAL.

Ports:
- nCLK  in  1  pixel-bus clock; all logic on the falling edge.
- nRST  in  1  reset. Synchronous, active-low.
- nDSYNC  in  1  low marks the sync word on D_i.
- D_i  in  color_width_i  N64 data bus. Sync word: bit3 nVSYNC, bit2 nCLAMP, bit1 nHSYNC, bit0 nCSYNC.
- nForceDeBlur  in  1  pass-through into bit 1 of deblurparams_o.
- nDeBlurMan  in  1  pass-through into bit 0 of deblurparams_o.
- vdata_pre  out  3*color_width_i+4  registered previous word. Layout: {nVSYNC,nCLAMP,nHSYNC,nCSYNC,R,G,B}, sync in the top 4 bits, B in the LSBs.
- deblurparams_o  out  7  packed as {data_cnt[1:0], n64_480i, vmode, blurry_pixel_pos, nForceDeBlur, nDeBlurMan}.
- frame_start  out  1  one-cycle pulse on a detected nVSYNC falling edge.

Behaviour:
- Reset (nRST low at a falling nCLK edge) overrides everything. Reset values:
  - data_cnt=0, n64_480i=0, vmode=0, blurry_pixel_pos=1, frame_start=0.
  - vdata_pre sync bits=4'hF, colour bits=0.
  - line_cnt=0, line_par_prev=0, frame_valid=0.
- Edge detection is active only on cycles with nDSYNC=0, comparing vdata_pre sync bits against D_i[3:0]:
  - negedge nVSYNC = pre[3] & !D_i[3]
  - negedge nHSYNC = pre[1] & !D_i[1]
- data_cnt:
  - nDSYNC=0: next value 2'b01.
  - otherwise: +1, wrapping 3->0.
  - Value 0 marks the sync word; 1/2/3 mark R/G/B.
  - A missing nDSYNC lets it free-run and wrap; no error is flagged.
- vdata_pre capture, one cycle after the bus, so it holds the previous word while the current one is on D_i:
  - nDSYNC=0: sync bits <= D_i[3:0].
  - data_cnt=1: R <= D_i.
  - data_cnt=2: G <= D_i.
  - data_cnt=3: B <= D_i.
- blurry_pixel_pos:
  - On every nDSYNC=0 cycle, toggles.
  - If negedge nHSYNC is detected in that same cycle, it is set to 1 instead; HSYNC wins over the toggle.
- line_cnt (10 bit):
  - +1 on each negedge nHSYNC, saturating at 1023.
  - Cleared to 0 on negedge nVSYNC. If both edges fall in the same word, the clear wins.
- On negedge nVSYNC:
  - frame_start=1 for exactly one cycle.
  - line_par_prev <= line_cnt[0].
  - frame_valid <= 1.
  - If frame_valid=1 (a previous vsync exists):
    - vmode <= (line_cnt >= PAL_LINE_TH).
    - n64_480i <= (line_cnt[0] != line_par_prev).
  - The first vsync after reset only arms detection; vmode and n64_480i stay unchanged.
- Outputs are registered. deblurparams_o is updated from the registers with no additional delay.
- Latency:
  - data_cnt and blurry_pixel_pos: 1 nCLK after the bus word.
  - Mode decisions: at the vsync edge that closes the frame.

Optional Feature:
- Macro: N64_480I_CONFIRM_EN.
- Defined:
  - A change of n64_480i requires two consecutive frame evaluations giving the same new value.
  - A 1-bit pending flag tracks the first of the two evaluations.
  - The flag is cleared on reset and whenever an evaluation agrees with the current n64_480i.
  - vmode is unaffected.
- Undefined: n64_480i follows each evaluation immediately.

Test Plan:
- Reset: hold nRST=0 for 3 cycles with random D_i.
  -> deblurparams_o=7'b00_0_0_1_xx (pass-through bits follow inputs), frame_start=0, vdata_pre[3cw+3:3cw]=4'hF.
- Bus phasing: nDSYNC pattern low,high,high,high with words S,R=0x11,G=0x22,B=0x33.
  -> data_cnt sequence 1,2,3,0.
  -> vdata_pre colour fields = 0x11/0x22/0x33 one cycle after each word.
  -> blurry_pixel_pos toggles once per 4 cycles.
- HSYNC realign: drive an nHSYNC falling edge at a pixel where blurry_pixel_pos=1.
  -> blurry_pixel_pos stays 1 (not 0).
  -> line_cnt increments by 1.
- NTSC 240p: frames of 263 lines repeated, 3 frames.
  -> frame_start pulses 3 times.
  -> after the 2nd vsync: vmode=0, n64_480i=0.
- PAL 480i: alternating 313/312-line frames.
  -> vmode=1 and n64_480i=1 after the 2nd vsync.
  -> with N64_480I_CONFIRM_EN, n64_480i=1 only after the 3rd vsync.
- Mid-frame reset: pulse nRST low during line 100 of a 480i stream.
  -> n64_480i=0, vmode=0 immediately.
  -> no mode update at the next vsync.
  -> correct classification resumes after the following vsync.

Source files
------------

// File: rtl/n64_vinfo_seq.sv
// N64 video-info sequencer: bus phase tracking, previous-word capture, per-frame PAL/480i classification.
// Optional build macro N64_480I_CONFIRM_EN: a 480i/240p change needs two agreeing frame evaluations.
module n64_vinfo_seq #(
    parameter int         color_width_i = 7,
    parameter logic [9:0] PAL_LINE_TH   = 10'd288
) (
    input  logic                         nCLK,
    input  logic                         nRST,
    input  logic                         nDSYNC,
    input  logic [color_width_i-1:0]     D_i,
    input  logic                         nForceDeBlur,
    input  logic                         nDeBlurMan,
    output logic [3*color_width_i+3:0]   vdata_pre,
    output logic [6:0]                   deblurparams_o,
    output logic                         frame_start
);

    localparam int CW = color_width_i;

    logic [1:0]    data_cnt_q,      data_cnt_d;
    logic [3:0]    sync_q,          sync_d;
    logic [CW-1:0] r_q,             r_d;
    logic [CW-1:0] g_q,             g_d;
    logic [CW-1:0] b_q,             b_d;
    logic          blurry_q,        blurry_d;
    logic [9:0]    line_cnt_q,      line_cnt_d;
    logic          line_par_prev_q, line_par_prev_d;
    logic          frame_valid_q,   frame_valid_d;
    logic          vmode_q,         vmode_d;
    logic          n64_480i_q,      n64_480i_d;
    logic          frame_start_q,   frame_start_d;
`ifdef N64_480I_CONFIRM_EN
    logic          pending_q,       pending_d;
`endif

    logic vs_fall;
    logic hs_fall;
    logic eval_480i;

    // Edges are only meaningful on the sync word, against the sync bits of the previous sync word.
    assign vs_fall   = !nDSYNC & sync_q[3] & !D_i[3];
    assign hs_fall   = !nDSYNC & sync_q[1] & !D_i[1];
    assign eval_480i = line_cnt_q[0] ^ line_par_prev_q;

    always_comb begin
        data_cnt_d      = nDSYNC ? data_cnt_q + 2'd1 : 2'd1;
        sync_d          = nDSYNC ? sync_q : D_i[3:0];
        r_d             = (data_cnt_q == 2'd1) ? D_i : r_q;
        g_d             = (data_cnt_q == 2'd2) ? D_i : g_q;
        b_d             = (data_cnt_q == 2'd3) ? D_i : b_q;
        blurry_d        = blurry_q;
        line_cnt_d      = line_cnt_q;
        line_par_prev_d = line_par_prev_q;
        frame_valid_d   = frame_valid_q;
        vmode_d         = vmode_q;
        n64_480i_d      = n64_480i_q;
        frame_start_d   = vs_fall;
`ifdef N64_480I_CONFIRM_EN
        pending_d       = pending_q;
`endif

        if (!nDSYNC)
            blurry_d = hs_fall | ~blurry_q;

        if (vs_fall)
            line_cnt_d = 10'd0;
        else if (hs_fall && line_cnt_q != 10'h3FF)
            line_cnt_d = line_cnt_q + 10'd1;

        // The first vsync after reset has no complete frame behind it, so it only arms.
        if (vs_fall) begin
            line_par_prev_d = line_cnt_q[0];
            frame_valid_d   = 1'b1;
            if (frame_valid_q) begin
                vmode_d = (line_cnt_q >= PAL_LINE_TH);
`ifdef N64_480I_CONFIRM_EN
                if (eval_480i == n64_480i_q) begin
                    pending_d = 1'b0;
                end else if (pending_q) begin
                    n64_480i_d = eval_480i;
                    pending_d  = 1'b0;
                end else begin
                    pending_d = 1'b1;
                end
`else
                n64_480i_d = eval_480i;
`endif
            end
        end
    end

    always_ff @(negedge nCLK) begin
        if (!nRST) begin
            data_cnt_q      <= 2'd0;
            sync_q          <= 4'hF;
            r_q             <= '0;
            g_q             <= '0;
            b_q             <= '0;
            blurry_q        <= 1'b1;
            line_cnt_q      <= 10'd0;
            line_par_prev_q <= 1'b0;
            frame_valid_q   <= 1'b0;
            vmode_q         <= 1'b0;
            n64_480i_q      <= 1'b0;
            frame_start_q   <= 1'b0;
`ifdef N64_480I_CONFIRM_EN
            pending_q       <= 1'b0;
`endif
        end else begin
            data_cnt_q      <= data_cnt_d;
            sync_q          <= sync_d;
            r_q             <= r_d;
            g_q             <= g_d;
            b_q             <= b_d;
            blurry_q        <= blurry_d;
            line_cnt_q      <= line_cnt_d;
            line_par_prev_q <= line_par_prev_d;
            frame_valid_q   <= frame_valid_d;
            vmode_q         <= vmode_d;
            n64_480i_q      <= n64_480i_d;
            frame_start_q   <= frame_start_d;
`ifdef N64_480I_CONFIRM_EN
            pending_q       <= pending_d;
`endif
        end
    end

    assign vdata_pre      = {sync_q, r_q, g_q, b_q};
    assign deblurparams_o = {data_cnt_q, n64_480i_q, vmode_q, blurry_q, nForceDeBlur, nDeBlurMan};
    assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_n64_vinfo_seq.sv
// Bench for n64_vinfo_seq: directed video streams with random pixel data, checked against a frame-level model.
module tb_n64_vinfo_seq;

    localparam int CW = 7;

    logic            nCLK;
    logic            nRST;
    logic            nDSYNC;
    logic [CW-1:0]   D_i;
    logic            nForceDeBlur;
    logic            nDeBlurMan;
    logic [3*CW+3:0] vdata_pre;
    logic [6:0]      deblurparams_o;
    logic            frame_start;

    int checks   = 0;
    int failures = 0;
    int fs_seen  = 0;

    // reference model state
    int         m_phase;
    logic [3:0] m_sync;
    logic [6:0] m_r, m_g, m_b;
    bit         m_blur;
    int         m_lines;
    bit         m_prev_odd, m_armed, m_pal, m_i480, m_pend, m_fs;

    n64_vinfo_seq #(.color_width_i(CW), .PAL_LINE_TH(10'd288)) dut (
        .nCLK           (nCLK),
        .nRST           (nRST),
        .nDSYNC         (nDSYNC),
        .D_i            (D_i),
        .nForceDeBlur   (nForceDeBlur),
        .nDeBlurMan     (nDeBlurMan),
        .vdata_pre      (vdata_pre),
        .deblurparams_o (deblurparams_o),
        .frame_start    (frame_start)
    );

    initial nCLK = 1'b1;
    always #5 nCLK = ~nCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A frame has closed: classify it from its line count and parity relative to the one before.
    task automatic close_frame();
        bit odd;
        odd = (m_lines % 2) == 1;
        if (m_armed) begin
            m_pal = (m_lines >= 288);
`ifdef N64_480I_CONFIRM_EN
            if ((odd != m_prev_odd) == m_i480) m_pend = 0;
            else if (m_pend) begin m_i480 = !m_i480; m_pend = 0; end
            else m_pend = 1;
`else
            m_i480 = (odd != m_prev_odd);
`endif
        end
        m_prev_odd = odd;
        m_armed    = 1;
    endtask

    task automatic model(input bit rst_n, input bit nds, input logic [6:0] d);
        bit vs_edge, hs_edge;
        int old;
        if (!rst_n) begin
            m_phase = 0; m_sync = 4'hF; m_r = 0; m_g = 0; m_b = 0; m_blur = 1;
            m_lines = 0; m_prev_odd = 0; m_armed = 0; m_pal = 0; m_i480 = 0; m_pend = 0; m_fs = 0;
            return;
        end
        vs_edge = !nds && m_sync[3] && !d[3];
        hs_edge = !nds && m_sync[1] && !d[1];
        old     = m_phase;
        m_phase = nds ? (m_phase + 1) % 4 : 1;
        if (!nds) m_sync = d[3:0];
        if (old == 1) m_r = d;
        if (old == 2) m_g = d;
        if (old == 3) m_b = d;
        if (!nds) m_blur = hs_edge ? 1 : !m_blur;
        m_fs = vs_edge;
        if (vs_edge) begin
            close_frame();
            m_lines = 0;
        end else if (hs_edge && m_lines < 1023) begin
            m_lines++;
        end
    endtask

    task automatic step(input bit rst_n, input bit nds, input logic [6:0] d);
        logic [6:0] exp_par;
        nRST = rst_n; nDSYNC = nds; D_i = d;
        nForceDeBlur = 1'($urandom); nDeBlurMan = 1'($urandom);
        @(negedge nCLK);
        #1;
        model(rst_n, nds, d);
        exp_par = {2'(m_phase), m_i480, m_pal, m_blur, nForceDeBlur, nDeBlurMan};
        chk("deblurparams", 32'(deblurparams_o), 32'(exp_par));
        chk("vdata_pre", 32'(vdata_pre), 32'({m_sync, m_r, m_g, m_b}));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        if (frame_start === 1'b1) fs_seen++;
    endtask

    task automatic pixel(input bit vs, input bit hs);
        step(1, 0, {3'($urandom), vs, 1'b1, hs, vs & hs});
        repeat (3) step(1, 1, 7'($urandom));
    endtask

    task automatic line(input bit vs);
        pixel(vs, 0);
        pixel(vs, 1);
    endtask

    task automatic frame(input int n);
        line(0);
        repeat (n - 1) line(1);
    endtask

    initial begin
        int fs0;
        nRST = 0; nDSYNC = 1; D_i = 0; nForceDeBlur = 1; nDeBlurMan = 0;

        repeat (3) step(0, 1'($urandom), 7'($urandom));
        chk("rst_params_hi", 32'(deblurparams_o[6:2]), 32'h01);
        chk("rst_params_pass", 32'(deblurparams_o[1:0]), 32'({nForceDeBlur, nDeBlurMan}));
        chk("rst_frame_start", 32'(frame_start), 32'h0);
        chk("rst_sync_bits", 32'(vdata_pre[3*CW+3:3*CW]), 32'hF);

        step(1, 0, 7'h0F);
        chk("phase_dc1", 32'(deblurparams_o[6:5]), 32'd1);
        chk("phase_blur0", 32'(deblurparams_o[2]), 32'd0);
        step(1, 1, 7'h11);
        chk("phase_dc2", 32'(deblurparams_o[6:5]), 32'd2);
        chk("phase_r", 32'(vdata_pre[3*CW-1:2*CW]), 32'h11);
        step(1, 1, 7'h22);
        chk("phase_dc3", 32'(deblurparams_o[6:5]), 32'd3);
        chk("phase_g", 32'(vdata_pre[2*CW-1:CW]), 32'h22);
        step(1, 1, 7'h33);
        chk("phase_dc0", 32'(deblurparams_o[6:5]), 32'd0);
        chk("phase_b", 32'(vdata_pre[CW-1:0]), 32'h33);
        step(1, 0, 7'h0F);
        chk("phase_blur1", 32'(deblurparams_o[2]), 32'd1);
        repeat (3) step(1, 1, 7'($urandom));

        step(1, 0, 7'h0D);
        chk("hsync_realign", 32'(deblurparams_o[2]), 32'd1);
        repeat (3) step(1, 1, 7'($urandom));

        repeat (60) step(1, ($urandom % 4) != 0, 7'($urandom));

        repeat (2) step(0, 1'($urandom), 7'($urandom));
        fs0 = fs_seen;
        frame(263);
        frame(263);
        chk("ntsc_vmode", 32'(deblurparams_o[3]), 32'd0);
        chk("ntsc_480i", 32'(deblurparams_o[4]), 32'd0);
        frame(263);
        chk("ntsc_fs_pulses", 32'(fs_seen - fs0), 32'd3);

        repeat (2) step(0, 1'($urandom), 7'($urandom));
        frame(312);
        frame(313);
        chk("pal_vmode_v2", 32'(deblurparams_o[3]), 32'd1);
`ifdef N64_480I_CONFIRM_EN
        chk("pal_480i_v2", 32'(deblurparams_o[4]), 32'd0);
`else
        chk("pal_480i_v2", 32'(deblurparams_o[4]), 32'd1);
`endif
        frame(312);
        chk("pal_480i_v3", 32'(deblurparams_o[4]), 32'd1);
        frame(313);

        line(0);
        repeat (99) line(1);
        step(0, 1'($urandom), 7'($urandom));
        chk("midrst_480i", 32'(deblurparams_o[4]), 32'd0);
        chk("midrst_vmode", 32'(deblurparams_o[3]), 32'd0);
        repeat (213) line(1);
        frame(313);
        chk("midrst_arm_vmode", 32'(deblurparams_o[3]), 32'd0);
        chk("midrst_arm_480i", 32'(deblurparams_o[4]), 32'd0);
        frame(312);
        chk("midrst_vmode", 32'(deblurparams_o[3]), 32'd1);
`ifdef N64_480I_CONFIRM_EN
        chk("midrst_480i_a", 32'(deblurparams_o[4]), 32'd0);
`else
        chk("midrst_480i_a", 32'(deblurparams_o[4]), 32'd1);
`endif
        frame(313);
        chk("midrst_480i_b", 32'(deblurparams_o[4]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
